// File: rtl/fetch_redirect_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_redirect_pkg                                               |
// | Opcode/funct values and decode FSM states shared by the ID side. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fetch_redirect_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_branch_resolve.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_redirect_branch_resolve                                    |
// | Combinational ID-stage branch/jump decode and branch target add. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_redirect_branch_resolve
  import fetch_redirect_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] if_id_instr,
  input  logic [DATA_W-1:0] rsData,
  input  logic [DATA_W-1:0] rtData,
  input  logic [ADDR_W-1:0] if_id_pc1,
  output logic              take_br,
  output logic              take_j,
  output logic              take_jr,
  output logic [ADDR_W-1:0] adderResult
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_equal;
  logic       w_unused_bits;

  assign w_op    = if_id_instr[31:26];
  assign w_funct = if_id_instr[5:0];
  assign w_equal = (rsData == rtData);

  assign take_br = ((w_op == OP_BEQ) &&  w_equal) ||
                   ((w_op == OP_BNE) && !w_equal);
  assign take_j  = (w_op == OP_J) || (w_op == OP_JAL);
  assign take_jr = (w_op == OP_RTYPE) && (w_funct == FN_JR);

  // Immediate is truncated to the address width; the sum wraps freely.
  assign adderResult = if_id_pc1 + if_id_instr[ADDR_W-1:0];

  assign w_unused_bits = ^{if_id_instr[25:16], if_id_instr[15:ADDR_W]};

endmodule
`default_nettype wire

// File: rtl/fetch_redirect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_redirect                                                   |
// | IF/ID register, ID-stage redirect and stall replay into fetch.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instruction,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] PCPlus1,
  input  logic              stall,
  input  logic [DATA_W-1:0] rsData,
  input  logic [DATA_W-1:0] rtData,
  output logic              PCsrc,
  output logic              jump,
  output logic              jr,
  output logic [ADDR_W-1:0] reg1Addr,
  output logic [ADDR_W-1:0] jaddress,
  output logic [ADDR_W-1:0] adderResult,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc1,
  output logic              if_id_valid,
  output logic              flush,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_if_id_instr;
  logic [ADDR_W-1:0] r_if_id_pc1;
  logic              r_if_id_valid;
  logic [CNT_W-1:0]  r_taken_cnt;

  logic              w_take_br;
  logic              w_take_j;
  logic              w_take_jr;
  logic [ADDR_W-1:0] w_adder;
  logic              w_br;
  logic              w_j;
  logic              w_jr;
  logic              w_redirect;
  logic              w_capture;
  logic              w_squash;

  fetch_redirect_branch_resolve #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_branch_resolve (
    .if_id_instr (r_if_id_instr),
    .rsData      (rsData),
    .rtData      (rtData),
    .if_id_pc1   (r_if_id_pc1),
    .take_br     (w_take_br),
    .take_j      (w_take_j),
    .take_jr     (w_take_jr),
    .adderResult (w_adder)
  );

  assign w_br       = r_if_id_valid & w_take_br;
  assign w_j        = r_if_id_valid & w_take_j;
  assign w_jr       = r_if_id_valid & w_take_jr;
  assign w_redirect = w_br | w_j | w_jr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_squash     = 1'b0;
    PCsrc        = 1'b0;
    jump         = 1'b0;
    jr           = 1'b0;
    flush        = 1'b0;
    reg1Addr     = '0;
    jaddress     = '0;
    adderResult  = '0;
    if (rst) begin
      reg1Addr    = rsData[ADDR_W-1:0];
      adderResult = w_adder;
      jaddress    = r_if_id_instr[ADDR_W-1:0];
      case (r_state)
        S_BOOT: w_state_next = S_RUN;
        default: begin
          if (stall) begin
            w_state_next = S_HOLD;
          end else begin
            w_state_next = S_RUN;
            w_squash     = w_redirect;
            w_capture    = !w_redirect;
          end
        end
      endcase
      // Fetch has no enable: a stall is a jump back onto fetch's own PC.
      if (stall) begin
        jump     = 1'b1;
        jaddress = PC;
      end else begin
        PCsrc = w_br;
        jump  = w_j | w_jr;
        jr    = w_jr;
        flush = w_redirect;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_if_id_instr <= '0;
      r_if_id_pc1   <= '0;
      r_if_id_valid <= 1'b0;
      r_taken_cnt   <= '0;
    end else if (w_squash) begin
      r_if_id_instr <= '0;
      r_if_id_pc1   <= '0;
      r_if_id_valid <= 1'b0;
      if (r_taken_cnt != '1) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
    end else if (w_capture) begin
      r_if_id_instr <= instruction;
      r_if_id_pc1   <= PCPlus1;
      r_if_id_valid <= 1'b1;
    end
  end

  assign if_id_instr = r_if_id_instr;
  assign if_id_pc1   = r_if_id_pc1;
  assign if_id_valid = r_if_id_valid;
  assign taken_cnt   = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_redirect                                                |
// | Directed and random stimulus against a behavioural ID model.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fetch_redirect;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int AMASK  = (1 << ADDR_W) - 1;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] instruction = '0;
  logic [ADDR_W-1:0] PC = '0;
  logic [ADDR_W-1:0] PCPlus1 = '0;
  logic              stall = 1'b0;
  logic [DATA_W-1:0] rsData = '0;
  logic [DATA_W-1:0] rtData = '0;
  logic              PCsrc, jump, jr, if_id_valid, flush;
  logic [ADDR_W-1:0] reg1Addr, jaddress, adderResult, if_id_pc1;
  logic [DATA_W-1:0] if_id_instr;
  logic [CNT_W-1:0]  taken_cnt;

  always #5 clk = ~clk;

  fetch_redirect #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .PC(PC), .PCPlus1(PCPlus1),
    .stall(stall), .rsData(rsData), .rtData(rtData), .PCsrc(PCsrc), .jump(jump),
    .jr(jr), .reg1Addr(reg1Addr), .jaddress(jaddress), .adderResult(adderResult),
    .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid),
    .flush(flush), .taken_cnt(taken_cnt)
  );

  logic [DATA_W-1:0] imem [0:AMASK];
  int tests = 0;
  int fails = 0;
  string phase = "init";

  // Reference model: architectural view of the IF/ID slot and counter
  logic [DATA_W-1:0] m_instr = '0;
  int m_pc1 = 0;
  bit m_valid = 0;
  int m_cnt = 0;
  bit m_boot = 1;
  int fpc = 0;
  bit x_pcsrc, x_jump, x_jr, x_flush;
  int x_jaddr, x_reg1, x_add;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s:%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic predict();
    int op, fn;
    bit br, jj, jrr;
    op  = int'(m_instr[31:26]);
    fn  = int'(m_instr[5:0]);
    br  = m_valid && ((op == 4 && rsData == rtData) || (op == 5 && rsData != rtData));
    jj  = m_valid && (op == 2 || op == 3);
    jrr = m_valid && op == 0 && fn == 8;
    x_pcsrc = 0; x_jump = 0; x_jr = 0; x_flush = 0;
    x_jaddr = 0; x_reg1 = 0; x_add = 0;
    if (rst) begin
      x_reg1 = int'(rsData) & AMASK;
      x_add  = (m_pc1 + (int'(m_instr[15:0]) & AMASK)) % (AMASK + 1);
      if (stall) begin
        x_jump  = 1;
        x_jaddr = int'(PC);
      end else begin
        x_pcsrc = br;
        x_jump  = jj || jrr;
        x_jr    = jrr;
        x_flush = br || jj || jrr;
        x_jaddr = int'(m_instr) & AMASK;
      end
    end
  endtask

  task automatic step(input logic [DATA_W-1:0] ins, input int pc, input bit st,
                      input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt);
    int nfpc;
    instruction = ins;
    PC          = ADDR_W'(pc);
    PCPlus1     = ADDR_W'((pc + 1) & AMASK);
    stall       = st;
    rsData      = rs;
    rtData      = rt;
    #1;
    predict();
    chk("PCsrc",       64'(PCsrc),       64'(x_pcsrc));
    chk("jump",        64'(jump),        64'(x_jump));
    chk("jr",          64'(jr),          64'(x_jr));
    chk("flush",       64'(flush),       64'(x_flush));
    chk("jaddress",    64'(jaddress),    64'(x_jaddr));
    chk("reg1Addr",    64'(reg1Addr),    64'(x_reg1));
    chk("adderResult", 64'(adderResult), 64'(x_add));
    chk("if_id_instr", 64'(if_id_instr), 64'(m_instr));
    chk("if_id_pc1",   64'(if_id_pc1),   64'(m_pc1));
    chk("if_id_valid", 64'(if_id_valid), 64'(m_valid));
    chk("taken_cnt",   64'(taken_cnt),   64'(m_cnt));
    if (!rst)         nfpc = 0;
    else if (m_boot)  nfpc = pc;
    else if (x_jump)  nfpc = x_jr ? x_reg1 : x_jaddr;
    else if (x_pcsrc) nfpc = x_add;
    else              nfpc = (pc + 1) & AMASK;
    @(posedge clk);
    if (!rst) begin
      m_instr = '0; m_pc1 = 0; m_valid = 0; m_cnt = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!st) begin
      if (x_flush) begin
        m_instr = '0; m_pc1 = 0; m_valid = 0;
        if (m_cnt < CMAX) m_cnt++;
      end else begin
        m_instr = ins; m_pc1 = (pc + 1) & AMASK; m_valid = 1;
      end
    end
    fpc = nfpc;
    @(negedge clk);
  endtask

  task automatic fstep(input bit st, input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt);
    step(imem[fpc], fpc, st, rs, rt);
  endtask

  function automatic logic [DATA_W-1:0] rand_instr();
    logic [DATA_W-1:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[31:26] = 6'h04;
      1: r[31:26] = 6'h05;
      2: r[31:26] = 6'($urandom_range(2, 3));
      3: begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
      4: r[31:26] = 6'h00;
      default: ;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] beq_i;
  logic [DATA_W-1:0] rnd_rs;

  initial begin
    for (int i = 0; i <= AMASK; i++) imem[i] = {6'h08, 26'(i)};
    imem[5]     = {6'h04, 5'd1, 5'd2, 16'd3};
    imem[10]    = {6'h05, 5'd1, 5'd2, 16'd7};
    imem[11]    = {6'h00, 5'd1, 15'd0, 6'h08};
    imem[AMASK] = {6'h02, 26'd0};
    beq_i       = {6'h04, 5'd3, 5'd4, 16'd2};

    phase = "reset";
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_instr = '0; m_pc1 = 0; m_valid = 0; m_cnt = 0; m_boot = 1; fpc = 0;
    step(imem[0], 0, 0, 1, 2);
    rst = 1'b1;

    phase = "seq";
    repeat (4) fstep(0, 1, 2);
    chk("instr2_in_order", 64'(if_id_instr), 64'(imem[2]));
    fstep(0, 1, 2);
    fstep(0, 1, 2);
    fstep(0, 1, 2);

    phase = "beq";
    rsData = 7; rtData = 7;
    #1;
    chk("beq_target", 64'(adderResult), 64'd9);
    chk("beq_pcsrc",  64'(PCsrc),       64'd1);
    fstep(0, 7, 7);
    chk("bubble", 64'(if_id_valid), 64'd0);
    fstep(0, 7, 7);
    chk("instr_at_9", 64'(if_id_instr), 64'(imem[9]));
    chk("cnt_one",    64'(taken_cnt),   64'd1);

    phase = "bne";
    fstep(0, 5, 5);
    fstep(0, 5, 5);
    chk("bne_fallthru", 64'(if_id_instr), 64'(imem[11]));
    chk("bne_cnt",      64'(taken_cnt),   64'd1);

    phase = "jr_j";
    rsData = 32'h3FF;
    #1;
    chk("jr_reg1", 64'(reg1Addr), 64'h3FF);
    fstep(0, 32'h3FF, 0);
    fstep(0, 0, 0);
    chk("wrap_pc1", 64'(if_id_pc1), 64'd0);
    fstep(0, 0, 0);
    fstep(0, 0, 0);
    chk("j_to_zero", 64'(if_id_instr), 64'(imem[0]));

    phase = "stall";
    step(beq_i, 11, 0, 4, 4);
    repeat (3) step(imem[12], 12, 1, 4, 4);
    chk("stall_hold", 64'(if_id_instr), 64'(beq_i));
    step(imem[12], 12, 0, 4, 4);
    chk("late_taken", 64'(taken_cnt), 64'd4);

    phase = "rst_mid";
    step(beq_i, 20, 0, 9, 9);
    rst = 1'b0;
    step(imem[21], 21, 0, 9, 9);
    chk("rst_valid", 64'(if_id_valid), 64'd0);
    chk("rst_cnt",   64'(taken_cnt),   64'd0);
    rst = 1'b1;

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 39) != 0);
      rnd_rs = $urandom;
      step(rand_instr(), int'($urandom_range(0, AMASK)), ($urandom_range(0, 3) == 0),
           rnd_rs, ($urandom_range(0, 1) == 0) ? rnd_rs : DATA_W'($urandom));
    end
    rst = 1'b1;

    phase = "saturate";
    rst = 1'b0;
    step(beq_i, 0, 0, 0, 0);
    rst = 1'b1;
    for (int n = 0; n < 2 * ((1 << CNT_W) + 2) + 1; n++) step(beq_i, n & AMASK, 0, 3, 3);
    chk("sat_cnt", 64'(taken_cnt), 64'(CMAX));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
